memory_cycle: RTL and testbench

MEMORY_CYCLE -- requirements
Module: memory_cycle

---
 rtl/memory_cycle.sv | 159 +++++++++++++++
 tb/tb_memory_cycle.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_cycle.sv
// memory_cycle: MEM stage of the pipeline. Runs 1-beat scalar or 4-beat
// vector word accesses on a 32-bit memory port, stalls upstream until the
// final beat completes, gathers load data and holds the MEM/WB register.
//
// Ports:
//   clk, rst (async, active-low)
//   M-stage inputs : RegWriteM, MemWriteM, ResultSrcM, is_vectorialM, RD_M,
//                    PCPlus4M, ALU_ResultM, WriteDataM
//   memory port    : mem_req, mem_we, mem_addr, mem_wdata (combinational
//                    beat request), mem_rdata, mem_ready
//   StallM         : combinational hold request to upstream stages
//   W-stage outputs: RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW,
//                    ReadDataW (registered)
module memory_cycle (
  input  logic         clk,
  input  logic         rst,
  input  logic         RegWriteM,
  input  logic         MemWriteM,
  input  logic         ResultSrcM,
  input  logic         is_vectorialM,
  input  logic [5:0]   RD_M,
  input  logic [31:0]  PCPlus4M,
  input  logic [127:0] ALU_ResultM,
  input  logic [127:0] WriteDataM,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_ready,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic         StallM,
  output logic         RegWriteW,
  output logic         ResultSrcW,
  output logic [5:0]   RD_W,
  output logic [31:0]  PCPlus4W,
  output logic [127:0] ALU_ResultW,
  output logic [127:0] ReadDataW
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned VLEN = 128;
  localparam int unsigned RW   = 6;
  localparam int unsigned BW   = 2;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;

  logic            reg_write_w_q, reg_write_w_d;
  logic            result_src_w_q, result_src_w_d;
  logic [RW-1:0]   rd_w_q, rd_w_d;
  logic [XLEN-1:0] pc_plus4_w_q, pc_plus4_w_d;
  logic [VLEN-1:0] alu_result_w_q, alu_result_w_d;
  logic [VLEN-1:0] read_data_w_q, read_data_w_d;

  logic            is_mem_c;
  logic            is_load_c;
  logic            active_c;
  logic            done_c;
  logic            final_c;
  logic [BW-1:0]   last_beat_c;
  logic [XLEN-1:0] base_c;

  // Access decode; a store+load combination behaves as a pure store.
  always_comb begin
    is_mem_c    = MemWriteM | ResultSrcM;
    is_load_c   = ResultSrcM & ~MemWriteM;
    last_beat_c = is_vectorialM ? BW'(3) : BW'(0);
    base_c      = {ALU_ResultM[XLEN-1:2], 2'b00};
    // Gated by rst so a reset kills the in-flight beat in the same cycle.
    active_c    = rst & ((state_q == BUSY) | is_mem_c);
    final_c     = (beat_q == last_beat_c);
    done_c      = active_c & mem_ready;
  end

  // FSM state register and beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // FSM next state: advance only when the current beat completes.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (done_c) begin
      if (final_c) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        state_d = BUSY;
        beat_d  = beat_q + BW'(1);
      end
    end
  end

  // FSM outputs: beat 0 goes out in IDLE, later beats from BUSY.
  always_comb begin
    mem_req   = active_c;
    mem_we    = active_c & MemWriteM;
    mem_addr  = '0;
    mem_wdata = '0;
    StallM    = active_c & ~(mem_ready & final_c);
    if (active_c) begin
      mem_addr  = base_c + XLEN'({beat_q, 2'b00});
      mem_wdata = WriteDataM[{beat_q, 5'b00000} +: XLEN];
    end
  end

  // MEM/WB next values: bubble while stalled, otherwise take M-stage values.
  always_comb begin
    reg_write_w_d  = StallM ? 1'b0 : RegWriteM;
    result_src_w_d = StallM ? result_src_w_q : ResultSrcM;
    rd_w_d         = StallM ? rd_w_q : RD_M;
    pc_plus4_w_d   = StallM ? pc_plus4_w_q : PCPlus4M;
    alu_result_w_d = StallM ? alu_result_w_q : ALU_ResultM;
    read_data_w_d  = read_data_w_q;
    if (done_c && is_load_c) begin
      // Beat 0 clears stale lanes so unwritten lanes read as zero.
      if (beat_q == '0) begin
        read_data_w_d = '0;
      end
      read_data_w_d[{beat_q, 5'b00000} +: XLEN] = mem_rdata;
    end
  end

  // MEM/WB register and load-data gather register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 1'b0;
      rd_w_q         <= '0;
      pc_plus4_w_q   <= '0;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
    end else begin
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      rd_w_q         <= rd_w_d;
      pc_plus4_w_q   <= pc_plus4_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
    end
  end

  assign RegWriteW   = reg_write_w_q;
  assign ResultSrcW  = result_src_w_q;
  assign RD_W        = rd_w_q;
  assign PCPlus4W    = pc_plus4_w_q;
  assign ALU_ResultW = alu_result_w_q;
  assign ReadDataW   = read_data_w_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: vector/scalar stores and loads, wait
// states, address wrap, non-memory ops and reset in the middle of an access.
module tb_memory_cycle;

  logic         clk = 1'b0;
  logic         rst;
  logic         RegWriteM, MemWriteM, ResultSrcM, is_vectorialM;
  logic [5:0]   RD_M;
  logic [31:0]  PCPlus4M;
  logic [127:0] ALU_ResultM, WriteDataM;
  logic [31:0]  mem_rdata;
  logic         mem_ready;
  logic         mem_req, mem_we, StallM;
  logic [31:0]  mem_addr, mem_wdata;
  logic         RegWriteW, ResultSrcW;
  logic [5:0]   RD_W;
  logic [31:0]  PCPlus4W;
  logic [127:0] ALU_ResultW, ReadDataW;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_addr  [6];
  logic [31:0] exp_wdata [4];
  logic        exp_stall [6];
  logic        rdy_seq   [6];
  logic [31:0] rd_seq    [6];
  int          stall_cnt;

  always #5 clk = ~clk;

  memory_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .is_vectorialM(is_vectorialM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step just past the rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic set_m(input logic rw, input logic mw, input logic rs, input logic vec,
                       input logic [5:0] rd, input logic [31:0] pc,
                       input logic [127:0] alu, input logic [127:0] wd);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; is_vectorialM = vec;
    RD_M = rd; PCPlus4M = pc; ALU_ResultM = alu; WriteDataM = wd;
  endtask

  initial begin
    rst = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, '0, '0);
    mem_rdata = '0;
    mem_ready = 1'b0;

    // Reset state, with a memory request present on the inputs.
    tick(); tick();
    set_m(1'b1, 1'b1, 1'b0, 1'b1, 6'd1, 32'h4, 128'h10, 128'h1);
    mem_ready = 1'b1;
    settle();
    chk("rst_req", mem_req, 1'b0);
    chk("rst_stall", StallM, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_regw", RegWriteW, 1'b0);
    chk("rst_aluw", ALU_ResultW, 128'h0);
    chk("rst_rdata", ReadDataW, 128'h0);

    // Vector store at 0x100, memory always ready.
    tick();
    rst = 1'b1;
    set_m(1'b1, 1'b1, 1'b0, 1'b1, 6'd3, 32'h1004, 128'h100,
          128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    mem_ready = 1'b1;
    exp_addr  = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h0, 32'h0};
    exp_wdata = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
    stall_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("vst_req%0d", k), mem_req, 1'b1);
      chk($sformatf("vst_we%0d", k), mem_we, 1'b1);
      chk($sformatf("vst_addr%0d", k), mem_addr, exp_addr[k]);
      chk($sformatf("vst_wdata%0d", k), mem_wdata, exp_wdata[k]);
      if (StallM) stall_cnt++;
      tick();
      if (k < 3) chk($sformatf("vst_bubble%0d", k), RegWriteW, 1'b0);
    end
    chk("vst_stall_cycles", stall_cnt, 3);
    chk("vst_regw", RegWriteW, 1'b1);
    chk("vst_rdw", RD_W, 6'd3);
    chk("vst_aluw", ALU_ResultW, 128'h100);
    chk("vst_pcw", PCPlus4W, 32'h1004);
    chk("vst_rdata_untouched", ReadDataW, 128'h0);

    // Vector load at 0x203 with two wait states on beat 1.
    set_m(1'b1, 1'b0, 1'b1, 1'b1, 6'd7, 32'h2008, 128'h203, '0);
    exp_addr  = '{32'h200, 32'h204, 32'h204, 32'h204, 32'h208, 32'h20C};
    exp_stall = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rdy_seq   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rd_seq    = '{32'h11111111, 32'hBAD0BAD0, 32'hBAD0BAD0,
                  32'h22222222, 32'h33333333, 32'h44444444};
    stall_cnt = 0;
    for (int s = 0; s < 6; s++) begin
      mem_ready = rdy_seq[s];
      mem_rdata = rd_seq[s];
      settle();
      chk($sformatf("vld_req%0d", s), mem_req, 1'b1);
      chk($sformatf("vld_we%0d", s), mem_we, 1'b0);
      chk($sformatf("vld_addr%0d", s), mem_addr, exp_addr[s]);
      chk($sformatf("vld_stall%0d", s), StallM, exp_stall[s]);
      if (StallM) stall_cnt++;
      tick();
      if (s == 0) chk("vld_lane0_partial", ReadDataW, 128'h11111111);
      if (s < 5) chk($sformatf("vld_bubble%0d", s), RegWriteW, 1'b0);
    end
    chk("vld_stall_cycles", stall_cnt, 5);
    chk("vld_rdata", ReadDataW, 128'h44444444_33333333_22222222_11111111);
    chk("vld_regw", RegWriteW, 1'b1);
    chk("vld_srcw", ResultSrcW, 1'b1);
    chk("vld_rdw", RD_W, 6'd7);
    chk("vld_aluw", ALU_ResultW, 128'h203);

    // Scalar load at 0x40: stale upper lanes must clear.
    set_m(1'b1, 1'b0, 1'b1, 1'b0, 6'd9, 32'h3000, 128'h40, '0);
    mem_ready = 1'b1;
    mem_rdata = 32'h12345678;
    settle();
    chk("sld_req", mem_req, 1'b1);
    chk("sld_addr", mem_addr, 32'h40);
    chk("sld_stall", StallM, 1'b0);
    tick();
    chk("sld_rdata", ReadDataW, 128'h12345678);
    chk("sld_regw", RegWriteW, 1'b1);
    chk("sld_rdw", RD_W, 6'd9);

    // Scalar store+load combination acts as a store at 0x54.
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 6'd10, 32'h3004, 128'h57,
          128'h99999999_88888888_77777777_CAFEF00D);
    mem_rdata = 32'hDEADBEEF;
    settle();
    chk("sst_we", mem_we, 1'b1);
    chk("sst_addr", mem_addr, 32'h54);
    chk("sst_wdata", mem_wdata, 32'hCAFEF00D);
    chk("sst_stall", StallM, 1'b0);
    tick();
    chk("sst_rdata_kept", ReadDataW, 128'h12345678);
    chk("sst_regw", RegWriteW, 1'b0);

    // Non-memory op: single cycle to W, no beat issued.
    set_m(1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 32'h3008, 128'h7, 128'hFFFF);
    settle();
    chk("alu_req", mem_req, 1'b0);
    chk("alu_stall", StallM, 1'b0);
    tick();
    chk("alu_rdw", RD_W, 6'd5);
    chk("alu_aluw", ALU_ResultW, 128'h7);
    chk("alu_regw", RegWriteW, 1'b1);
    chk("alu_pcw", PCPlus4W, 32'h3008);

    // Vector store wrapping past the top of the address space.
    set_m(1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 32'h300C, 128'hFFFFFFF8, 128'h0);
    exp_addr = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004, 32'h0, 32'h0};
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("wrap_addr%0d", k), mem_addr, exp_addr[k]);
      tick();
    end

    // Vector load at 0x300, reset asserted during beat 2.
    set_m(1'b1, 1'b0, 1'b1, 1'b1, 6'd11, 32'h4000, 128'h300, '0);
    mem_rdata = 32'h0A0A0A0A;
    tick(); tick();
    settle();
    chk("rab_addr_b2", mem_addr, 32'h308);
    chk("rab_partial", ReadDataW, 128'h0A0A0A0A_0A0A0A0A);
    rst = 1'b0;
    settle();
    chk("rab_req", mem_req, 1'b0);
    chk("rab_stall", StallM, 1'b0);
    chk("rab_addr", mem_addr, 32'h0);
    chk("rab_rdata", ReadDataW, 128'h0);
    chk("rab_aluw", ALU_ResultW, 128'h0);
    chk("rab_rdw", RD_W, 6'd0);
    chk("rab_pcw", PCPlus4W, 32'h0);
    chk("rab_srcw", ResultSrcW, 1'b0);
    tick();
    chk("rab_hold_req", mem_req, 1'b0);

    // After release a fresh vector load starts from beat 0.
    rst = 1'b1;
    set_m(1'b1, 1'b0, 1'b1, 1'b1, 6'd12, 32'h5000, 128'h400, '0);
    exp_addr = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h0, 32'h0};
    rd_seq   = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 32'h0, 32'h0};
    for (int k = 0; k < 4; k++) begin
      mem_rdata = rd_seq[k];
      settle();
      chk($sformatf("post_addr%0d", k), mem_addr, exp_addr[k]);
      chk($sformatf("post_stall%0d", k), StallM, (k < 3) ? 1'b1 : 1'b0);
      tick();
    end
    chk("post_rdata", ReadDataW, 128'h04040404_03030303_02020202_01010101);
    chk("post_rdw", RD_W, 6'd12);
    chk("post_regw", RegWriteW, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
